// File: rtl/lut_gate_settle.sv
// Configurable N-input lookup-table gate with a serially loaded truth table and
// a settle filter that only lets the output follow a function value that persists.
module lut_gate_settle #(
  parameter int                      N_IN    = 3,
  parameter int                      SETTLE  = 4,
  parameter logic [(1<<N_IN)-1:0]    INIT_TT = 8'hC4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  input  logic            cfg_last,
  output logic            cfg_ready,
  output logic            cfg_err,
  output logic            out,
  output logic            out_stable
);

  localparam int W  = 1 << N_IN;
  localparam int BW = $clog2(W + 2);

  localparam logic [BW-1:0] BC_ONE  = BW'(1);
  localparam logic [BW-1:0] BC_FULL = BW'(W);
  localparam logic [BW-1:0] BC_SAT  = BW'(W + 1);
  localparam logic [7:0]    CNT_TOP = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } cfg_state_t;

  cfg_state_t      state;
  cfg_state_t      state_nxt;
  logic            accept;
  logic            commit;

  logic [W-1:0]    active_tt;
  logic [W-1:0]    shadow;
  logic [BW-1:0]   bitcnt;

  logic [N_IN-1:0] in_q;
  logic [N_IN-1:0] tt_idx;
  logic            f;
  logic [7:0]      cnt;

  assign cfg_ready = (state != COMMIT);
  assign accept    = cfg_valid && cfg_ready;

  // Table bit (W-1-index) is simply the bitwise complement of the index.
  assign tt_idx     = ~in_q;
  assign f          = active_tt[tt_idx];
  assign out_stable = (f == out) && (cnt == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = cfg_last ? COMMIT : LOAD;
        end
      end
      LOAD: begin
        if (accept && cfg_last) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shadow register and bit counter; the counter sticks at W+1 so an
  // over-long stream can never wrap back to a "correct" length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_tt <= INIT_TT;
      shadow    <= '0;
      bitcnt    <= '0;
      cfg_err   <= 1'b0;
    end else if (commit) begin
      if (bitcnt == BC_FULL) begin
        active_tt <= shadow;
        cfg_err   <= 1'b0;
      end else begin
        cfg_err   <= 1'b1;
      end
      bitcnt <= '0;
    end else if (accept) begin
      shadow <= {shadow[W-2:0], cfg_bit};
      if (state == IDLE) begin
        bitcnt <= BC_ONE;
      end else if (bitcnt != BC_SAT) begin
        bitcnt <= bitcnt + BC_ONE;
      end
    end
  end

  // Settle filter: out follows f only after f has differed for SETTLE edges.
  // A commit restarts the count so the new table's value settles normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= '0;
      cnt  <= '0;
      out  <= INIT_TT[W-1];
    end else begin
      in_q <= in;
      if (commit) begin
        cnt <= '0;
      end else if (f != out) begin
        if (cnt == CNT_TOP) begin
          out <= f;
          cnt <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: doc/lut_gate_settle.md
LUT_GATE_SETTLE -- requirements
Module: lut_gate_settle

Interface
REQ-001 Parameter N_IN, default 3, number of logic inputs, legal range 1..6.
REQ-002 Parameter SETTLE, default 4, cycles a new function value must persist before out changes, legal range 1..255.
REQ-003 Parameter INIT_TT, default 8'hC4, width 2**N_IN, truth table loaded at reset.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in  input  N_IN  logic inputs; in[N_IN-1] is input 1 (most significant index bit).
REQ-007 cfg_valid  input  1  config bit offered.
REQ-008 cfg_bit  input  1  config data bit.
REQ-009 cfg_last  input  1  marks final config bit of a table.
REQ-010 cfg_ready  output  1  block accepts config bit this cycle.
REQ-011 cfg_err  output  1  sticky, last load had wrong length.
REQ-012 out  output  1  registered, settled gate output.
REQ-013 out_stable  output  1  high when out equals current function value and no change is pending.

Function
REQ-014 Truth-table ordering SHALL be: index = {in1..inN} as unsigned; table bit (2**N_IN-1-index) gives the function value (MSB = all-zero inputs).
REQ-015 in SHALL be registered once into in_q; function value f = active_tt bit selected by in_q, combinational from in_q.
REQ-016 Settle counter cnt (8 bits): f != out -> cnt increments; f == out -> cnt clears to 0.
REQ-017 When f != out and cnt == SETTLE-1, out SHALL take f at that edge and cnt SHALL clear; out therefore changes SETTLE edges after in_q changes, SETTLE+1 edges after in changes.
REQ-018 A function value that reverts before SETTLE consecutive cycles SHALL produce no output change (glitch rejection).
REQ-019 out_stable = (f == out) and (cnt == 0).
REQ-020 Config FSM states: IDLE, LOAD, COMMIT.
REQ-021 IDLE: cfg_valid accepted -> shift cfg_bit into shadow LSB, bitcnt=1, go LOAD (or COMMIT if cfg_last).
REQ-022 LOAD: each accepted bit shifts into shadow LSB (MSB-first stream), bitcnt increments, saturating at 2**N_IN+1; accepted cfg_last -> COMMIT.
REQ-023 COMMIT lasts exactly one cycle with cfg_ready low; bitcnt == 2**N_IN -> active_tt <= shadow, cfg_err <= 0; otherwise active_tt unchanged, cfg_err <= 1; then IDLE, bitcnt=0.
REQ-024 cfg_ready SHALL be high in IDLE and LOAD, low in COMMIT; a bit is accepted only when cfg_valid and cfg_ready are both high.
REQ-025 A table commit SHALL clear cnt; the new f then passes through the normal settle path (no immediate out change).
REQ-026 Input changes during LOAD SHALL be evaluated against the old active_tt until the commit edge.

Reset
REQ-027 rst_n low SHALL asynchronously set: active_tt=INIT_TT, shadow=0, bitcnt=0, FSM=IDLE, in_q=0, cnt=0, cfg_err=0, out=INIT_TT MSB.
REQ-028 Outputs during and after reset: out=INIT_TT MSB, out_stable=1, cfg_ready=1, cfg_err=0.
REQ-029 Reset asserted mid-load SHALL discard the partial table; active_tt returns to INIT_TT.

Verification (N_IN=3, SETTLE=4, INIT_TT=8'hC4)
REQ-030 Reset with in=000 -> out=1, out_stable=1, cfg_ready=1, cfg_err=0.
REQ-031 in 000->010 held -> out_stable falls one edge later; out falls to 0 exactly 5 edges after in changes; out_stable returns to 1.
REQ-032 in=010 for 2 cycles, then 000 -> out stays 1 throughout, cnt returns to 0.
REQ-033 in=111, load 8 bits of 8'h01 MSB-first with cfg_last on bit 8 -> cfg_ready low for one COMMIT cycle; out rises to 1 four edges after commit; cfg_err=0.
REQ-034 Load 5 bits with cfg_last on bit 5 -> cfg_err=1, table stays 8'hC4; following 8-bit load clears cfg_err.
REQ-035 Assert rst_n low after 4 config bits -> after release active table 8'hC4, bitcnt=0, FSM IDLE, out=1 with in=000.
